// File: rtl/fetch_pc_unit.sv
// Program counter and next-PC selection for the single-cycle RV32I core.
// Holds the PC across I-cache waits and D-cache miss stalls, and latches the redirect target.
module fetch_pc_unit #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter logic [XLEN-1:0]  TRAP_VEC = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            branch_signal,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] imm_ext,
  input  logic            imem_ready,
  input  logic            stall_in,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            instr_valid,
  output logic            misalign_err,
  output logic [XLEN-1:0] instret
);

  typedef enum logic [1:0] {StBoot, StFetch, StStall} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] redirect_q;
  logic [XLEN-1:0] instret_q;
  logic            imem_req_q;
  logic            misalign_q;

  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;
  logic            target_misaligned;

  always_comb begin
    target_raw = pc_q + XLEN'(4);
    if (is_jalr) begin
      target_raw = {alu_result[XLEN-1:1], 1'b0};
    end else if (is_jal) begin
      target_raw = pc_q + imm_ext;
    end else if (is_branch && branch_signal) begin
      target_raw = pc_q + imm_ext;
    end
    target_misaligned = target_raw[1];
    target            = target_misaligned ? TRAP_VEC : target_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      redirect_q <= '0;
      instret_q  <= '0;
      imem_req_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot: begin
          state_q    <= StFetch;
          imem_req_q <= 1'b1;
        end
        StFetch: begin
          if (imem_ready) begin
            misalign_q <= misalign_q | target_misaligned;
            if (stall_in) begin
              // Target is captured now; inputs are not looked at again until the stall clears.
              redirect_q <= target;
              state_q    <= StStall;
              imem_req_q <= 1'b0;
            end else begin
              pc_q      <= target;
              instret_q <= instret_q + XLEN'(1);
            end
          end
        end
        StStall: begin
          if (!stall_in) begin
            pc_q       <= redirect_q;
            instret_q  <= instret_q + XLEN'(1);
            state_q    <= StFetch;
            imem_req_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= StBoot;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + XLEN'(4);
  assign instr_valid  = (state_q == StFetch) && imem_ready;
  assign misalign_err = misalign_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: the driver queues the expected fetch state per instruction,
// a monitor pops and compares it on every cycle the DUT presents a valid instruction.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_branch, is_jal, is_jalr, branch_signal;
  logic [31:0] alu_result, imm_ext;
  logic        imem_ready, stall_in;
  logic        imem_req;
  logic [31:0] imem_addr, pc, pc_plus4, instret;
  logic        instr_valid, misalign_err;

  fetch_pc_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .is_branch    (is_branch),
    .is_jal       (is_jal),
    .is_jalr      (is_jalr),
    .branch_signal(branch_signal),
    .alu_result   (alu_result),
    .imm_ext      (imm_ext),
    .imem_ready   (imem_ready),
    .stall_in     (stall_in),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid),
    .misalign_err (misalign_err),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Monitor: every presented instruction must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_fetch: got pc %h want no instruction", pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("imem_addr", imem_addr, e.pc);
        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        chk("instret", instret, e.inst);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
        chk("imem_req", {31'd0, imem_req}, 32'd1);
      end
    end
  end

  task automatic drv(input logic b, input logic j, input logic jr, input logic bs,
                     input logic [31:0] alu, input logic [31:0] imm,
                     input logic ready, input logic stall);
    is_branch = b; is_jal = j; is_jalr = jr; branch_signal = bs;
    alu_result = alu; imm_ext = imm; imem_ready = ready; stall_in = stall;
  endtask

  // One fetched instruction: expected values are those visible during its fetch cycle.
  task automatic fetch(input logic b, input logic j, input logic jr, input logic bs,
                       input logic [31:0] alu, input logic [31:0] imm, input logic stall,
                       input logic [31:0] epc, input logic [31:0] einst, input logic emis);
    exp_t e;
    drv(b, j, jr, bs, alu, imm, 1'b1, stall);
    e.pc = epc; e.inst = einst; e.mis = emis;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic boot_check(input string tag);
    @(negedge clk);
    chk({tag, "_boot_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_boot_pc"}, pc, 32'h0);
    @(posedge clk); #1;
    chk({tag, "_fetch_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, "_fetch_addr"}, imem_addr, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1;
    boot_check("rel1");

    // Sequential fetch, then branch taken / not taken.
    fetch(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h00, 32'd0, 0);
    fetch(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h04, 32'd1, 0);
    fetch(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h08, 32'd2, 0);
    fetch(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0C, 32'd3, 0);
    fetch(1, 0, 0, 1, 32'h0, 32'hFFFF_FFF8, 0, 32'h10, 32'd4, 0);
    fetch(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h08, 32'd5, 0);
    fetch(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0C, 32'd6, 0);
    fetch(1, 0, 0, 0, 32'h0, 32'hFFFF_FFF8, 0, 32'h10, 32'd7, 0);
    // JALR aligned (bit0 cleared), then misaligned -> trap vector.
    fetch(0, 0, 1, 0, 32'h101, 32'h0, 0, 32'h14, 32'd8, 0);
    fetch(0, 0, 1, 0, 32'h106, 32'h0, 0, 32'h100, 32'd9, 0);
    fetch(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h100, 32'd10, 1);
    fetch(0, 1, 0, 0, 32'h0, 32'hFFFF_FF1C, 0, 32'h104, 32'd11, 1);
    // JAL latched into a stall; immediate changes during the stall must be ignored.
    fetch(0, 1, 0, 0, 32'h0, 32'h40, 1, 32'h20, 32'd12, 1);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 32'h0, 32'h0, 1'b1, (i < 2));
      @(negedge clk);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_pc", pc, 32'h20);
      chk("stall_valid", {31'd0, instr_valid}, 32'd0);
      chk("stall_instret", instret, 32'd12);
      @(posedge clk); #1;
    end
    fetch(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h60, 32'd13, 1);
    // All controls asserted: jalr must win.
    fetch(1, 1, 1, 1, 32'h300, 32'h8, 0, 32'h64, 32'd14, 1);
    // I-cache not ready: pc held, no retire.
    drv(0, 1, 0, 0, 32'h0, 32'h8, 1'b0, 1'b0);
    @(negedge clk);
    chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    chk("wait_req", {31'd0, imem_req}, 32'd1);
    @(posedge clk); #1;
    fetch(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h300, 32'd15, 1);

    // Reset in the middle of a stall discards the redirect.
    fetch(0, 1, 0, 0, 32'h0, 32'h40, 1, 32'h304, 32'd16, 1);
    drv(0, 0, 0, 0, 32'h0, 32'h0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_instret", instret, 32'h0);
    chk("async_mis", {31'd0, misalign_err}, 32'd0);
    chk("async_req", {31'd0, imem_req}, 32'd0);
    drv(0, 0, 0, 0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    boot_check("rel2");

    // PC wrap-around.
    fetch(0, 1, 0, 0, 32'h0, 32'hFFFF_FFFC, 0, 32'h0, 32'd0, 0);
    fetch(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'hFFFF_FFFC, 32'd1, 0);
    fetch(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'd2, 0);
    drv(0, 0, 0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    chk("final_instret", instret, 32'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
